axi2apb_bridge_core: RTL
========================

// Module: axi2apb_bridge_core
// PURPOSE
//  AXI3 slave to APB3 master bridge; consumes AW/W/B/AR/R channels driven by the AXI master agent.
//  Serialises each AXI burst into back-to-back APB transfers, one beat per APB transfer.
//  One outstanding transaction at a time; sits between the AXI fabric/BFM and the APB slave bus.
// PARAMETERS
//  ADDR_WIDTH  `AXI_ADDR_WIDTH  AXI and APB address width
//  DATA_WIDTH  `AXI_DATA_WIDTH  data width (32); beat size fixed to DATA_WIDTH/8 bytes
//  ID_WIDTH    `AXI_ID_WIDTH    AXI ID width; IDs echoed on B/R
// PORTS
//  clk      in   1           single clock, all logic on posedge
//  rst_n    in   1           asynchronous active-low reset
//  aw_ch    if   AXI_AW_CH   write address; bridge drives awready
//  w_ch     if   AXI_W_CH    write data; bridge drives wready
//  b_ch     if   AXI_B_CH    write response; bridge drives bvalid/bid/bresp
//  ar_ch    if   AXI_AR_CH   read address; bridge drives arready
//  r_ch     if   AXI_R_CH    read data; bridge drives rvalid/rid/rdata/rresp/rlast
//  paddr    out  ADDR_WIDTH  APB address
//  psel     out  1           APB select
//  penable  out  1           APB enable (ACCESS phase)
//  pwrite   out  1           APB direction, 1=write
//  pwdata   out  DATA_WIDTH  APB write data
//  prdata   in   DATA_WIDTH  APB read data
//  pready   in   1           APB ready; wait states allowed
//  pslverr  in   1           APB slave error, valid with pready
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, psel=penable=pwrite=0, paddr/pwdata/rdata=0, bresp/rresp=OKAY, FSM=IDLE.
//  Reset mid-burst aborts instantly; no response issued for the aborted burst.
//  FSM: IDLE, WDATA, SETUP, ACCESS, RDATA, BRESP.
//  IDLE: if awvalid -> awready=1 for exactly 1 cycle, latch id/addr/len/burst, -> WDATA.
//   else if arvalid -> arready=1 for 1 cycle, latch, -> SETUP(pwrite=0). Write wins simultaneous AW+AR.
//  awready/arready/wready are registered single-cycle pulses, never held high across two handshakes.
//  WDATA: wready=1 for 1 cycle when wvalid seen; latch wdata into pwdata -> SETUP(pwrite=1).
//  SETUP: psel=1, penable=0, one cycle -> ACCESS.  ACCESS: psel=1, penable=1, hold until pready.
//  On pready: write -> OR pslverr into sticky err; last beat ? BRESP : WDATA.
//   read -> capture prdata, rresp=SLVERR(2'b10) if pslverr else OKAY; -> RDATA.
//  RDATA: rvalid=1, rlast=(beat==len); hold rdata/rresp until rready; then last ? IDLE : SETUP.
//  BRESP: bvalid=1, bresp=err?SLVERR:OKAY, bid=latched id; on bready -> IDLE, clear err.
//  psel deasserted in WDATA/RDATA/BRESP/IDLE; APB never idles inside ACCESS without pready.
//  Beat counter 4 bits (awlen/arlen 0..15); beat count = len+1.
//  Address per beat: FIXED(00) constant; INCR(01) +4; WRAP(10) +4 wrapping at (len+1)*4 aligned
//   boundary, len+1 in {2,4,8,16}; reserved(11) treated as INCR.
//  wlast ignored for sequencing (counter rules); wstrb ignored, full-word writes.
//  Minimum latency: AR handshake -> first rvalid = 3 cycles with pready=1 (SETUP, ACCESS, RDATA).
// STRUCTURE
//  axi2apb_pkg: state enum, BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, BEAT_BYTES constant.
//  Sub-module axi_burst_addr_gen: start addr, len, burst, step strobe -> current beat address.
//  Top holds FSM, beat counter, error flag, data/response registers.
// TESTING
//  INCR write len=4 @0x100, data 0x11..0x44, pready=1 -> APB writes 0x100/104/108/10C, one B OKAY.
//  INCR read len=4 @0x100 -> four R beats 0x11..0x44 in order, rlast only on beat 3, rresp OKAY.
//  WRAP read len=4 @0x108 -> APB addrs 0x108,0x10C,0x100,0x104.
//  FIXED write len=3 @0x200, pready low 2 cycles per beat -> paddr 0x200 x3, penable held during waits.
//  pslverr on beat 1 of 4-beat write -> bresp=SLVERR; same on read -> only beat 1 rresp=SLVERR.
//  awvalid+arvalid same cycle -> write completes (B) before arready pulses; rst_n low mid-read -> all outputs 0.

Source files
------------

// File: rtl/axi2apb_pkg.sv
// Shared types and constants for the AXI3-to-APB3 bridge.
package axi2apb_pkg;

    localparam int unsigned BEAT_BYTES = 4;
    localparam int unsigned LEN_W      = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_RDATA,
        ST_BRESP
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [1:0]       burst;
    } burst_cfg_t;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address generator for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
    import axi2apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  burst_cfg_t            cfg_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    burst_cfg_t            cfg_q, cfg_d;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic                  wrap_ok;

    assign incr_addr = addr_q + ADDR_WIDTH'(BEAT_BYTES);
    assign wrap_mask = ADDR_WIDTH'((32'(cfg_q.len) + 32'd1) * BEAT_BYTES) - ADDR_WIDTH'(1);
    // Only power-of-two beat counts 2..16 are legal wrap lengths; others fall back to INCR.
    assign wrap_ok   = (cfg_q.len == 4'd1) || (cfg_q.len == 4'd3) ||
                       (cfg_q.len == 4'd7) || (cfg_q.len == 4'd15);

    always_comb begin
        addr_d = addr_q;
        cfg_d  = cfg_q;
        if (load_i) begin
            addr_d = start_addr_i;
            cfg_d  = cfg_i;
        end else if (step_i) begin
            case (cfg_q.burst)
                BURST_FIXED: addr_d = addr_q;
                BURST_WRAP:  addr_d = wrap_ok ? ((addr_q & ~wrap_mask) | (incr_addr & wrap_mask))
                                              : incr_addr;
                default:     addr_d = incr_addr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cfg_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cfg_q  <= cfg_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/axi2apb_bridge_core.sv
// AXI3 slave to APB3 master bridge; one outstanding burst, one APB transfer per beat.
module axi2apb_bridge_core
    import axi2apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [LEN_W-1:0]        awlen_i,
    input  logic [1:0]              awburst_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [LEN_W-1:0]        arlen_i,
    input  logic [1:0]              arburst_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    state_e                  state_q, state_d;
    logic                    awready_q, awready_d, arready_q, arready_d, wready_q, wready_d;
    logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic                    psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic                    err_q, err_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [LEN_W-1:0]        len_q, len_d, beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d, bresp_q, bresp_d;
    logic                    gen_load, gen_step, is_last;
    logic [ADDR_WIDTH-1:0]   gen_start, beat_addr;
    burst_cfg_t              gen_cfg;
    logic                    unused_w;

    assign unused_w = ^{wstrb_i, wlast_i};
    assign is_last  = (beat_q == len_q);

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (gen_load),
        .start_addr_i (gen_start),
        .cfg_i        (gen_cfg),
        .step_i       (gen_step),
        .addr_o       (beat_addr)
    );

    always_comb begin
        state_d   = state_q;
        awready_d = 1'b0;
        arready_d = 1'b0;
        wready_d  = 1'b0;
        pwrite_d  = pwrite_q;
        err_d     = err_q;
        id_d      = id_q;
        len_d     = len_q;
        beat_d    = beat_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        bresp_d   = bresp_q;
        gen_load  = 1'b0;
        gen_step  = 1'b0;
        gen_start = '0;
        gen_cfg   = '0;

        case (state_q)
            ST_IDLE: begin
                // Write wins when AW and AR arrive together.
                if (awvalid_i) begin
                    awready_d = 1'b1;
                    id_d      = awid_i;
                    len_d     = awlen_i;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    pwrite_d  = 1'b1;
                    gen_load  = 1'b1;
                    gen_start = awaddr_i;
                    gen_cfg   = '{len: awlen_i, burst: awburst_i};
                    state_d   = ST_WDATA;
                end else if (arvalid_i) begin
                    arready_d = 1'b1;
                    id_d      = arid_i;
                    len_d     = arlen_i;
                    beat_d    = '0;
                    pwrite_d  = 1'b0;
                    gen_load  = 1'b1;
                    gen_start = araddr_i;
                    gen_cfg   = '{len: arlen_i, burst: arburst_i};
                    paddr_d   = araddr_i;
                    state_d   = ST_SETUP;
                end
            end
            ST_WDATA: begin
                if (wvalid_i) begin
                    wready_d = 1'b1;
                    pwdata_d = wdata_i;
                    paddr_d  = beat_addr;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_i) begin
                    gen_step = 1'b1;
                    beat_d   = beat_q + 4'd1;
                    if (pwrite_q) begin
                        err_d   = err_q | pslverr_i;
                        bresp_d = resp_of(err_q | pslverr_i);
                        state_d = is_last ? ST_BRESP : ST_WDATA;
                    end else begin
                        rdata_d = prdata_i;
                        rresp_d = resp_of(pslverr_i);
                        rlast_d = is_last;
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (rready_i) begin
                    rlast_d = 1'b0;
                    paddr_d = rlast_q ? paddr_q : beat_addr;
                    state_d = rlast_q ? ST_IDLE : ST_SETUP;
                end
            end
            ST_BRESP: begin
                if (bready_i) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake/select outputs are registered images of the next state.
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        rvalid_d  = (state_d == ST_RDATA);
        bvalid_d  = (state_d == ST_BRESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            err_q     <= 1'b0;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            err_q     <= err_d;
            id_q      <= id_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready_o = awready_q;
    assign arready_o = arready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bid_o     = id_q;
    assign bresp_o   = bresp_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = id_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;
    assign paddr_o   = paddr_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;

endmodule
